// File: rtl/op_entry_ctrl.sv
// op_entry_ctrl
//   Front-end controller for the operator/display datapath. Conditions three
//   raw push-buttons (2-flop sync, debounce, single-cycle rising-edge pulse)
//   and sequences operand A -> operator -> operand B -> result entry.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   sw[4:0]    raw operand switches (synchronised internally)
//   btn_op     raw button: advance operator
//   btn_enter  raw button: confirm current step
//   btn_clear  raw button: abort and restart entry
//   choose     operator code, 0..NUM_OPS-1
//   en         1 = display shows ALU result, 0 = display shows f
//   opa, opb   latched operands
//   f          LED value when en=0
//   state      FSM state for debug (0=S_A 1=S_OP 2=S_B 3=S_RES)
module op_entry_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int NUM_OPS         = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] sw,
  input  logic       btn_op,
  input  logic       btn_enter,
  input  logic       btn_clear,
  output logic [2:0] choose,
  output logic       en,
  output logic [4:0] opa,
  output logic [4:0] opb,
  output logic [4:0] f,
  output logic [1:0] state
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0]    OP_LAST  = 3'(NUM_OPS - 1);

  typedef enum logic [1:0] {S_A = 2'd0, S_OP = 2'd1, S_B = 2'd2, S_RES = 2'd3} state_t;

  // Button bit order: [2]=clear, [1]=enter, [0]=op
  logic [2:0] btn_raw;
  logic [2:0] btn_s1_reg, btn_s2_reg;
  logic [4:0] sw_s1_reg, sw_s2_reg;
  logic [1:0] warm_reg;
  logic [2:0] pulse;

  assign btn_raw = {btn_clear, btn_enter, btn_op};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1_reg <= '0;
      btn_s2_reg <= '0;
      sw_s1_reg  <= '0;
      sw_s2_reg  <= '0;
      warm_reg   <= '0;
    end else begin
      btn_s1_reg <= btn_raw;
      btn_s2_reg <= btn_s1_reg;
      sw_s1_reg  <= sw;
      sw_s2_reg  <= sw_s1_reg;
      // Counts the two edges needed before the sync stage reflects the pins.
      if (warm_reg != 2'd2) warm_reg <= warm_reg + 2'd1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_btn
      logic [CW-1:0] cnt_reg;
      logic          db_reg;
      logic          db_d_reg;
      logic          armed_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg   <= '0;
          db_reg    <= 1'b0;
          db_d_reg  <= 1'b0;
          armed_reg <= 1'b0;
        end else begin
          db_d_reg <= db_reg;
          // Count consecutive cycles the synced level disagrees with the
          // accepted level; any agreement restarts the count.
          if (btn_s2_reg[gi] != db_reg) begin
            if (cnt_reg == CNT_LAST) begin
              db_reg  <= btn_s2_reg[gi];
              cnt_reg <= '0;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end else begin
            cnt_reg <= '0;
          end
          // A button only becomes able to pulse once it has been seen
          // released after reset, so a press held through reset is ignored.
          if (warm_reg == 2'd2 && !btn_s2_reg[gi]) armed_reg <= 1'b1;
        end
      end

      assign pulse[gi] = db_reg & ~db_d_reg & armed_reg;
    end
  endgenerate

  logic p_clear, p_enter, p_op;
  assign p_clear = pulse[2];
  assign p_enter = pulse[1];
  assign p_op    = pulse[0];

  state_t     state_reg;
  logic [2:0] choose_reg;
  logic       en_reg;
  logic [4:0] opa_reg, opb_reg, f_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_A;
      choose_reg <= '0;
      en_reg     <= 1'b0;
      opa_reg    <= '0;
      opb_reg    <= '0;
      f_reg      <= '0;
    end else begin
      // Default display value for staying in the current state.
      case (state_reg)
        S_A:     f_reg <= sw_s2_reg;
        S_OP:    f_reg <= opa_reg;
        S_B:     f_reg <= sw_s2_reg;
        default: f_reg <= opb_reg;
      endcase

      if (p_clear) begin
        state_reg  <= S_A;
        choose_reg <= '0;
        opa_reg    <= '0;
        opb_reg    <= '0;
        en_reg     <= 1'b0;
        f_reg      <= sw_s2_reg;
      end else if (p_enter) begin
        case (state_reg)
          S_A: begin
            opa_reg   <= sw_s2_reg;
            f_reg     <= sw_s2_reg;
            state_reg <= S_OP;
          end
          S_OP: begin
            f_reg     <= sw_s2_reg;
            state_reg <= S_B;
          end
          S_B: begin
            opb_reg   <= sw_s2_reg;
            f_reg     <= sw_s2_reg;
            en_reg    <= 1'b1;
            state_reg <= S_RES;
          end
          default: begin
            en_reg    <= 1'b0;
            f_reg     <= sw_s2_reg;
            state_reg <= S_A;
          end
        endcase
      end else if (p_op && state_reg == S_OP) begin
        choose_reg <= (choose_reg >= OP_LAST) ? 3'd0 : choose_reg + 3'd1;
      end
    end
  end

  assign choose = choose_reg;
  assign en     = en_reg;
  assign opa    = opa_reg;
  assign opb    = opb_reg;
  assign f      = f_reg;
  assign state  = state_reg;

endmodule

// File: tb/tb_op_entry_ctrl.sv
// tb_op_entry_ctrl
//   Directed bench for op_entry_ctrl with DEBOUNCE_CYCLES=4, NUM_OPS=5.
//   Walks the full entry sequence, operator wrap, glitch rejection,
//   coincident clear/enter and asynchronous reset with a held button.
module tb_op_entry_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] sw;
  logic       btn_op, btn_enter, btn_clear;
  logic [2:0] choose;
  logic       en;
  logic [4:0] opa, opb, f;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;
  int n_chg  = 0;
  int chg_base;
  logic [1:0] last_state = 2'd0;

  op_entry_ctrl #(.DEBOUNCE_CYCLES(4), .NUM_OPS(5)) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw),
    .btn_op(btn_op), .btn_enter(btn_enter), .btn_clear(btn_clear),
    .choose(choose), .en(en), .opa(opa), .opb(opb), .f(f), .state(state)
  );

  always #5 clk = ~clk;

  // Counts state changes seen at sampling points.
  always @(negedge clk) begin
    if (state !== last_state) n_chg++;
    last_state = state;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Hold the masked buttons ({clear,enter,op}) for n cycles, then idle long
  // enough for the release to debounce.
  task automatic press(input logic [2:0] mask, input int n);
    @(posedge clk); #1;
    {btn_clear, btn_enter, btn_op} = mask;
    repeat (n) @(posedge clk);
    #1;
    {btn_clear, btn_enter, btn_op} = 3'b000;
    repeat (12) @(posedge clk);
    @(negedge clk);
    $display("press mask=%b cycles=%0d -> state=%0d choose=%0d en=%0d opa=%0h opb=%0h f=%0h",
             mask, n, state, choose, en, opa, opb, f);
  endtask

  localparam logic [2:0] OP = 3'b001, ENT = 3'b010, CLR = 3'b100;

  int exp_seq[6] = '{1, 2, 3, 4, 0, 1};

  initial begin
    rst_n = 1'b0;
    sw = 5'h00;
    {btn_clear, btn_enter, btn_op} = 3'b000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state", 32'(state), 0);
    check("rst_choose", 32'(choose), 0);
    check("rst_en", 32'(en), 0);
    check("rst_opa", 32'(opa), 0);
    check("rst_opb", 32'(opb), 0);
    check("rst_f", 32'(f), 0);
    rst_n = 1'b1;

    // Operand A entry
    sw = 5'h03;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("sa_live_f", 32'(f), 3);
    chg_base = n_chg;
    press(ENT, 10);
    check("a_state", 32'(state), 1);
    check("a_one_change", 32'(n_chg - chg_base), 1);
    check("a_opa", 32'(opa), 3);
    check("a_f", 32'(f), 3);
    check("a_choose", 32'(choose), 0);

    // Operator stepping with wrap
    for (int i = 0; i < 6; i++) begin
      press(OP, 10);
      check("op_step", 32'(choose), 32'(exp_seq[i]));
    end
    press(ENT, 10);
    check("b_state", 32'(state), 2);
    check("b_choose", 32'(choose), 1);

    // Operand B and result
    sw = 5'h0A;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("sb_live_f", 32'(f), 32'h0A);
    press(OP, 10);
    check("sb_op_ignored", 32'(choose), 1);
    press(ENT, 10);
    check("res_opb", 32'(opb), 32'h0A);
    check("res_en", 32'(en), 1);
    check("res_state", 32'(state), 3);
    check("res_f", 32'(f), 32'h0A);
    press(ENT, 10);
    check("back_en", 32'(en), 0);
    check("back_state", 32'(state), 0);
    check("back_opa", 32'(opa), 3);
    check("back_opb", 32'(opb), 32'h0A);
    check("back_choose", 32'(choose), 1);

    // Glitch rejection in S_OP
    press(ENT, 10);
    check("g_state", 32'(state), 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1; btn_op = 1'b1;
      repeat (2) @(posedge clk); #1; btn_op = 1'b0;
      repeat (3) @(posedge clk);
    end
    repeat (10) @(posedge clk);
    @(negedge clk);
    $display("glitch burst done -> choose=%0d", choose);
    check("glitch_choose", 32'(choose), 1);
    press(OP, 10);
    check("solid_choose", 32'(choose), 2);

    // Coincident clear and enter in S_B
    press(ENT, 10);
    check("c_state_b", 32'(state), 2);
    press(CLR | ENT, 10);
    check("clr_state", 32'(state), 0);
    check("clr_opa", 32'(opa), 0);
    check("clr_opb", 32'(opb), 0);
    check("clr_choose", 32'(choose), 0);
    check("clr_en", 32'(en), 0);

    // Async reset in S_RES with enter held
    press(ENT, 10);
    press(OP, 10);
    press(ENT, 10);
    press(ENT, 10);
    check("r_state_res", 32'(state), 3);
    check("r_choose", 32'(choose), 1);
    @(posedge clk); #1;
    btn_enter = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_state", 32'(state), 0);
    check("async_en", 32'(en), 0);
    check("async_opa", 32'(opa), 0);
    check("async_opb", 32'(opb), 0);
    check("async_choose", 32'(choose), 0);
    check("async_f", 32'(f), 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    chg_base = n_chg;
    repeat (20) @(posedge clk);
    @(negedge clk);
    $display("held enter through reset -> state=%0d", state);
    check("held_state", 32'(state), 0);
    check("held_no_change", 32'(n_chg - chg_base), 0);
    @(posedge clk); #1;
    btn_enter = 1'b0;
    repeat (12) @(posedge clk);
    press(ENT, 10);
    check("after_release", 32'(state), 1);
    check("after_opa", 32'(opa), 32'h0A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
